// File: rtl/sweep_pkg.sv
// Shared types and constants for the up/down sweep sequencer.
// Imported by the controller and its datapath.
package sweep_pkg;

    typedef enum logic [2:0] {
        IDLE,
        UP,
        HOLD_HI,
        DOWN,
        HOLD_LO
    } sweep_state_t;

    typedef enum logic [1:0] {
        OP_HOLD,
        OP_LOAD,
        OP_INC,
        OP_DEC
    } cnt_op_t;

    localparam logic DIR_UP   = 1'b0;
    localparam logic DIR_DOWN = 1'b1;

endpackage

// File: rtl/sweep_if.sv
// Requester-side bundle of the sweep sequencer: start/abort pulses, limits,
// sweep configuration, and the registered count/status returned to the consumer.
interface sweep_if #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 8
);
    logic             start;
    logic             abort;
    logic [WIDTH-1:0] lo;
    logic [WIDTH-1:0] hi;
    logic             dwell;
    logic [CNT_W-1:0] n_sweeps;
    logic [WIDTH-1:0] cont;
    logic             dir;
    logic             busy;
    logic             done;
    logic             err;
    logic [CNT_W-1:0] sweep_cnt;

    modport master (
        output start, abort, lo, hi, dwell, n_sweeps,
        input  cont, dir, busy, done, err, sweep_cnt
    );

    modport slave (
        input  start, abort, lo, hi, dwell, n_sweeps,
        output cont, dir, busy, done, err, sweep_cnt
    );
endinterface

// File: rtl/sweep_datapath.sv
// Count register of the sweep sequencer with load/inc/dec/hold control
// and equality flags against the latched limits.
module sweep_datapath
    import sweep_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  cnt_op_t          op,
    input  logic [WIDTH-1:0] load_val,
    input  logic [WIDTH-1:0] lo_lim,
    input  logic [WIDTH-1:0] hi_lim,
    output logic [WIDTH-1:0] cont,
    output logic             at_hi,
    output logic             at_lo
);
    logic [WIDTH-1:0] cont_d;
    logic [WIDTH-1:0] cont_q;

    // The controller never asks for inc at hi or dec at lo, so no wrap guard is needed.
    always_comb begin
        cont_d = cont_q;
        case (op)
            OP_LOAD: cont_d = load_val;
            OP_INC:  cont_d = cont_q + 1'b1;
            OP_DEC:  cont_d = cont_q - 1'b1;
            default: cont_d = cont_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) cont_q <= '0;
        else     cont_q <= cont_d;
    end

    assign cont  = cont_q;
    assign at_hi = (cont_q == hi_lim);
    assign at_lo = (cont_q == lo_lim);
endmodule

// File: rtl/sweep_ctrl.sv
// Bounce-sweep sequencer: runs the count between latched limits for a
// programmed number of round trips, with optional dwell and abort.
module sweep_ctrl
    import sweep_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int CNT_W = 8
) (
    input  logic    clk,
    input  logic    rst,
    sweep_if.slave  bus
);
    sweep_state_t     state_d, state_q;
    logic [WIDTH-1:0] lo_d, lo_q, hi_d, hi_q;
    logic             dwell_d, dwell_q;
    logic [CNT_W-1:0] n_sweeps_d, n_sweeps_q;
    logic [CNT_W-1:0] sweep_cnt_d, sweep_cnt_q;
    logic [CNT_W-1:0] sweep_inc;
    logic             dir_d, dir_q, busy_d, busy_q;
    logic             done_d, done_q, err_d, err_q;
    cnt_op_t          op;
    logic [WIDTH-1:0] cont;
    logic             at_hi, at_lo;

    sweep_datapath #(.WIDTH(WIDTH)) u_datapath (
        .clk      (clk),
        .rst      (rst),
        .op       (op),
        .load_val (bus.lo),
        .lo_lim   (lo_q),
        .hi_lim   (hi_q),
        .cont     (cont),
        .at_hi    (at_hi),
        .at_lo    (at_lo)
    );

    assign sweep_inc = sweep_cnt_q + CNT_W'(1);

    always_comb begin
        state_d     = state_q;
        lo_d        = lo_q;
        hi_d        = hi_q;
        dwell_d     = dwell_q;
        n_sweeps_d  = n_sweeps_q;
        sweep_cnt_d = sweep_cnt_q;
        dir_d       = dir_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        err_d       = 1'b0;
        op          = OP_HOLD;

        // Abort freezes count, direction and trip count where they stand.
        if (state_q != IDLE && bus.abort) begin
            state_d = IDLE;
            busy_d  = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        if (bus.lo < bus.hi) begin
                            lo_d        = bus.lo;
                            hi_d        = bus.hi;
                            dwell_d     = bus.dwell;
                            n_sweeps_d  = bus.n_sweeps;
                            sweep_cnt_d = '0;
                            dir_d       = DIR_UP;
                            busy_d      = 1'b1;
                            op          = OP_LOAD;
                            state_d     = UP;
                        end else begin
                            err_d = 1'b1;
                        end
                    end
                end
                UP: begin
                    if (at_hi) begin
                        dir_d = DIR_DOWN;
                        if (dwell_q) begin
                            state_d = HOLD_HI;
                        end else begin
                            op      = OP_DEC;
                            state_d = DOWN;
                        end
                    end else begin
                        op = OP_INC;
                    end
                end
                HOLD_HI: begin
                    op      = OP_DEC;
                    state_d = DOWN;
                end
                DOWN: begin
                    if (at_lo) begin
                        sweep_cnt_d = sweep_inc;
                        if (n_sweeps_q != '0 && sweep_inc == n_sweeps_q) begin
                            state_d = IDLE;
                            busy_d  = 1'b0;
                            done_d  = 1'b1;
                        end else begin
                            dir_d = DIR_UP;
                            if (dwell_q) begin
                                state_d = HOLD_LO;
                            end else begin
                                op      = OP_INC;
                                state_d = UP;
                            end
                        end
                    end else begin
                        op = OP_DEC;
                    end
                end
                HOLD_LO: begin
                    op      = OP_INC;
                    state_d = UP;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            lo_q        <= '0;
            hi_q        <= '0;
            dwell_q     <= 1'b0;
            n_sweeps_q  <= '0;
            sweep_cnt_q <= '0;
            dir_q       <= DIR_UP;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            lo_q        <= lo_d;
            hi_q        <= hi_d;
            dwell_q     <= dwell_d;
            n_sweeps_q  <= n_sweeps_d;
            sweep_cnt_q <= sweep_cnt_d;
            dir_q       <= dir_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            err_q       <= err_d;
        end
    end

    assign bus.cont      = cont;
    assign bus.dir       = dir_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.err       = err_q;
    assign bus.sweep_cnt = sweep_cnt_q;
endmodule

// File: tb/tb_sweep_ctrl.sv
// Directed self-checking bench for sweep_ctrl: single trip, dwell, continuous
// full-range run with wrap, rejected start, abort and asynchronous reset.
module tb_sweep_ctrl;
    localparam int WIDTH = 4;
    localparam int CNT_W = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   failures = 0;

    sweep_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus ();

    sweep_ctrl #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0d expected %0d at %0t", tag, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic s, input logic a, input logic [WIDTH-1:0] l,
                                 input logic [WIDTH-1:0] h, input logic d, input logic [CNT_W-1:0] n);
        bus.start    = s;
        bus.abort    = a;
        bus.lo       = l;
        bus.hi       = h;
        bus.dwell    = d;
        bus.n_sweeps = n;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_cont"}, 32'(bus.cont), 0);
        checkOutput({tag, "_dir"}, 32'(bus.dir), 0);
        checkOutput({tag, "_busy"}, 32'(bus.busy), 0);
        checkOutput({tag, "_done"}, 32'(bus.done), 0);
        checkOutput({tag, "_err"}, 32'(bus.err), 0);
        checkOutput({tag, "_sweep_cnt"}, 32'(bus.sweep_cnt), 0);
    endtask

    int exp_single[5] = '{2, 3, 4, 3, 2};
    int dir_single[5] = '{0, 0, 0, 1, 1};
    int exp_dwell[12] = '{2, 3, 4, 4, 3, 2, 2, 3, 4, 4, 3, 2};

    initial begin
        int m;
        int exp_cont;
        int exp_dir;
        int exp_sc;

        applyStimulus(0, 0, 0, 0, 0, 0);
        #2;
        checkAllZero("reset");
        @(negedge clk);
        rst = 1'b0;

        // Single trip, no dwell
        applyStimulus(1, 0, 2, 4, 0, 1);
        tick();
        applyStimulus(0, 0, 2, 4, 0, 1);
        for (int i = 0; i < 5; i++) begin
            if (i > 0) tick();
            checkOutput("single_cont", 32'(bus.cont), exp_single[i]);
            checkOutput("single_dir", 32'(bus.dir), dir_single[i]);
            checkOutput("single_busy", 32'(bus.busy), 1);
            checkOutput("single_done", 32'(bus.done), 0);
        end
        tick();
        checkOutput("single_end_done", 32'(bus.done), 1);
        checkOutput("single_end_busy", 32'(bus.busy), 0);
        checkOutput("single_end_cont", 32'(bus.cont), 2);
        checkOutput("single_end_sweep_cnt", 32'(bus.sweep_cnt), 1);
        tick();
        checkOutput("single_done_pulse", 32'(bus.done), 0);

        // Dwell, two round trips
        applyStimulus(1, 0, 2, 4, 1, 2);
        tick();
        applyStimulus(0, 0, 2, 4, 1, 2);
        for (int i = 0; i < 12; i++) begin
            if (i > 0) tick();
            checkOutput("dwell_cont", 32'(bus.cont), exp_dwell[i]);
            checkOutput("dwell_busy", 32'(bus.busy), 1);
            checkOutput("dwell_sweep_cnt", 32'(bus.sweep_cnt), (i >= 6) ? 1 : 0);
        end
        tick();
        checkOutput("dwell_end_done", 32'(bus.done), 1);
        checkOutput("dwell_end_busy", 32'(bus.busy), 0);
        checkOutput("dwell_end_sweep_cnt", 32'(bus.sweep_cnt), 2);

        // Rejected start, lo == hi
        applyStimulus(1, 0, 5, 5, 0, 1);
        tick();
        applyStimulus(0, 0, 5, 5, 0, 1);
        checkOutput("reject_err", 32'(bus.err), 1);
        checkOutput("reject_busy", 32'(bus.busy), 0);
        checkOutput("reject_cont", 32'(bus.cont), 2);
        tick();
        checkOutput("reject_err_pulse", 32'(bus.err), 0);

        // Continuous full range; period of 30 cycles after the first trip
        applyStimulus(1, 0, 0, 15, 0, 0);
        tick();
        applyStimulus(0, 0, 0, 15, 0, 0);
        for (int t = 0; t <= 7703; t++) begin
            if (t > 0) tick();
            m        = t % 30;
            exp_cont = (m <= 15) ? m : 30 - m;
            exp_dir  = (t > 0 && (m == 0 || m >= 16)) ? 1 : 0;
            exp_sc   = (t == 0) ? 0 : ((t - 1) / 30) % 256;
            checkOutput("cont_run_cont", 32'(bus.cont), exp_cont);
            checkOutput("cont_run_dir", 32'(bus.dir), exp_dir);
            checkOutput("cont_run_busy", 32'(bus.busy), 1);
            checkOutput("cont_run_done", 32'(bus.done), 0);
            checkOutput("cont_run_sweep_cnt", 32'(bus.sweep_cnt), exp_sc);
            if (t == 100) applyStimulus(1, 0, 3, 9, 1, 1);
            if (t == 101) applyStimulus(0, 0, 3, 9, 1, 1);
            if (t == 7703) applyStimulus(0, 1, 3, 9, 1, 1);
        end
        tick();
        applyStimulus(0, 0, 3, 9, 1, 1);
        checkOutput("abort_busy", 32'(bus.busy), 0);
        checkOutput("abort_cont", 32'(bus.cont), 7);
        checkOutput("abort_dir", 32'(bus.dir), 1);
        checkOutput("abort_done", 32'(bus.done), 0);
        checkOutput("abort_sweep_cnt", 32'(bus.sweep_cnt), 0);
        tick();
        checkOutput("abort_hold_cont", 32'(bus.cont), 7);
        checkOutput("abort_hold_done", 32'(bus.done), 0);

        // Start and abort together in IDLE: start wins
        applyStimulus(1, 1, 2, 4, 0, 1);
        tick();
        applyStimulus(0, 0, 2, 4, 0, 1);
        checkOutput("start_abort_cont", 32'(bus.cont), 2);
        checkOutput("start_abort_busy", 32'(bus.busy), 1);
        tick();
        checkOutput("start_abort_next_cont", 32'(bus.cont), 3);

        // Asynchronous reset between edges
        #1;
        rst = 1'b1;
        #1;
        checkAllZero("async_rst");
        #2;
        rst = 1'b0;
        applyStimulus(1, 0, 1, 3, 0, 1);
        tick();
        applyStimulus(0, 0, 1, 3, 0, 1);
        checkOutput("post_rst_cont", 32'(bus.cont), 1);
        checkOutput("post_rst_busy", 32'(bus.busy), 1);
        repeat (5) tick();
        checkOutput("post_rst_done", 32'(bus.done), 1);
        checkOutput("post_rst_sweep_cnt", 32'(bus.sweep_cnt), 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/sweep_ctrl.md
# sweep_ctrl

Sequencer for the up/down bounce counter: sweeps a WIDTH-bit count between programmable limits `lo` and `hi` for a programmed number of round trips, with an optional one-cycle dwell at each turnaround. It sits between a configuration/requester interface (start/abort pulses, limits) and the consumer of `cont`. It generalises the fixed 0..15 bounce counter into a configurable, stoppable, countable resource.

## Interface
- WIDTH, 4: counter width.
- CNT_W, 8: round-trip counter width.
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- start  in  1  one-cycle request; sampled only in IDLE.
- abort  in  1  synchronous stop; effective only while busy.
- lo  in  WIDTH  lower limit, latched on accepted start.
- hi  in  WIDTH  upper limit, latched on accepted start.
- dwell  in  1  1 = hold `cont` one extra cycle at each turnaround; latched on accepted start.
- n_sweeps  in  CNT_W  round trips to run; 0 = run until abort; latched on accepted start.
- cont  out  WIDTH  current count.
- dir  out  1  0 = counting up, 1 = counting down.
- busy  out  1  sweep in progress.
- done  out  1  one-cycle pulse on normal completion.
- err  out  1  one-cycle pulse on a rejected start (lo >= hi).
- sweep_cnt  out  CNT_W  completed round trips since the last accepted start.

## Operation
- States: IDLE, UP, HOLD_HI, DOWN, HOLD_LO.
- Reset: state IDLE; cont=0, dir=0, busy=0, done=0, err=0, sweep_cnt=0; latched config cleared.
- IDLE:
  - start with lo<hi: latch config, cont<=lo, dir<=0, sweep_cnt<=0, busy<=1, go to UP.
  - start with lo>=hi: err<=1 for one cycle; stay IDLE; cont unchanged.
  - cont holds its last value.
- UP:
  - cont!=hi: cont<=cont+1.
  - cont==hi: dir<=1. If dwell, go to HOLD_HI (cont holds). Otherwise cont<=cont-1, go to DOWN.
- HOLD_HI: cont<=cont-1; go to DOWN.
- DOWN:
  - cont!=lo: cont<=cont-1.
  - cont==lo: a round trip is complete; sweep_cnt<=sweep_cnt+1.
    - If n_sweeps!=0 and sweep_cnt+1==n_sweeps: go to IDLE, busy<=0, done<=1; cont stays lo.
    - Otherwise dir<=0. If dwell, go to HOLD_LO (cont holds). Otherwise cont<=cont+1, go to UP.
- HOLD_LO: cont<=cont+1; go to UP.
- abort while busy: takes priority over every transition. Next edge: IDLE, busy<=0, cont/dir/sweep_cnt frozen, no done pulse.
- start while busy: ignored.
- start and abort together in IDLE: start is processed; abort is ignored.
- Arithmetic:
  - cont never leaves [lo, hi], so there is no wrap; hi = 2^WIDTH-1 is legal.
  - sweep_cnt wraps modulo 2^CNT_W only in n_sweeps=0 mode.
- Limit/config changes while busy have no effect until the next accepted start.

## Timing
- All outputs are registered; no combinational input-to-output paths.
- Accepted start at edge k: cont=lo and busy=1 from k.
- One round trip with dwell=0 occupies 2*(hi-lo)+1 busy cycles; dwell=1 adds 1 cycle at hi and 1 cycle at lo, except after the final trip.
- done rises one cycle after the last busy cycle, together with busy falling.
- err and done are single-cycle pulses.
- rst mid-sweep returns all outputs to reset values immediately (asynchronous).

## Structure
- Package sweep_pkg:
  - typedef enum sweep_state_t {IDLE, UP, HOLD_HI, DOWN, HOLD_LO}.
  - DIR_UP=0 and DIR_DOWN=1 constants.
- Sub-module sweep_datapath:
  - Holds the cont register, with load (value lo), inc, dec and hold controls.
  - Outputs the at_hi and at_lo compare flags.
- sweep_ctrl contains the FSM, config latches, sweep_cnt, and the done/err pulse logic.

## Test plan
- Single trip, no dwell: lo=2, hi=4, dwell=0, n_sweeps=1, start -> cont 2,3,4,3,2 with busy=1; next cycle done=1, busy=0, cont=2, sweep_cnt=1.
- Dwell: lo=2, hi=4, dwell=1, n_sweeps=2 -> cont 2,3,4,4,3,2,2,3,4,4,3,2; then done=1, sweep_cnt=2.
- Full range, continuous: lo=0, hi=15, n_sweeps=0 -> cont turns 15→14 and 0→1 with no wrap; sweep_cnt increments at each 0 and wraps 255→0; done never pulses.
- Rejected start: lo=5, hi=5 -> err=1 for one cycle; busy stays 0; cont unchanged.
- Abort: abort in the cycle where cont=7 during DOWN -> next cycle busy=0, cont=7, dir=1, done=0. A start during busy is ignored and sweep_cnt is unaffected.
- Async reset: assert rst mid-UP between clock edges -> all outputs 0 immediately. A start in the first cycle after release is accepted.
